// File: rtl/line_mem_pkg.sv
// line_mem_pkg
// Shared definitions for the line memory: the controller state type, the
// default parameter values and a helper that sizes the latency counter.
// No ports; imported by line_mem and line_mem_array.

package line_mem_pkg;

    // Controller states: waiting for a request, counting down the access
    // latency, and the single completion cycle.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_ADDR_W     = 8;
    localparam int DEF_LATENCY    = 3;

    // The counter only ever holds LATENCY-1 down to 0; keep at least one bit
    // so the LATENCY=1 build still has a legal vector.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/line_mem_array.sv
// line_mem_array
// Word-organised storage for line_mem.
//   clk      : write clock
//   we       : commit a line write this edge
//   wstrb    : per-word write enable, bit i covers word i of the line
//   addr     : line-aligned word address shared by the line write and read
//   wdata    : write line, word i at [DATA_W*(i+1)-1 : DATA_W*i]
//   rdata    : combinational read of the line at addr, same packing
//   dbg_addr : debug word address
//   dbg_data : combinational word at dbg_addr

module line_mem_array
    import line_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W
) (
    input  logic                         clk,
    input  logic                         we,
    input  logic [LINE_WORDS-1:0]        wstrb,
    input  logic [ADDR_W-1:0]            addr,
    input  logic [DATA_W*LINE_WORDS-1:0] wdata,
    output logic [DATA_W*LINE_WORDS-1:0] rdata,
    input  logic [ADDR_W-1:0]            dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int DEPTH = 1 << ADDR_W;

    // Contents start at zero at power-up; reset deliberately leaves them alone.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

    // Line write: only strobed words change. addr is aligned and the depth is
    // a whole number of lines, so addr+i never wraps.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < LINE_WORDS; i++) begin
                if (wstrb[i]) begin
                    mem[addr + ADDR_W'(i)] <= wdata[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Whole-line combinational read.
    always_comb begin
        rdata = '0;
        for (int i = 0; i < LINE_WORDS; i++) begin
            rdata[i*DATA_W +: DATA_W] = mem[addr + ADDR_W'(i)];
        end
    end

    assign dbg_data = mem[dbg_addr];

endmodule

// File: rtl/line_mem.sv
// line_mem
// Line-oriented memory with a fixed access latency.
//   clk, rst        : clock and asynchronous active-high reset
//   mem_req_valid   : request present (sampled only in IDLE)
//   mem_req_rw      : 1 = write, 0 = read
//   mem_req_addr    : word address, low log2(LINE_WORDS) bits ignored
//   mem_req_wstrb   : per-word write enable
//   mem_data_write  : write line
//   mem_data_read   : registered read line, held until the next read completes
//   mem_ready       : one-cycle completion pulse
//   mem_busy        : high whenever an operation is in flight
//   dbg_addr        : debug word address
//   dbg_data        : combinational word at dbg_addr

module line_mem
    import line_mem_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LATENCY    = DEF_LATENCY
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         mem_req_valid,
    input  logic                         mem_req_rw,
    input  logic [ADDR_W-1:0]            mem_req_addr,
    input  logic [LINE_WORDS-1:0]        mem_req_wstrb,
    input  logic [DATA_W*LINE_WORDS-1:0] mem_data_write,
    output logic [DATA_W*LINE_WORDS-1:0] mem_data_read,
    output logic                         mem_ready,
    output logic                         mem_busy,
    input  logic [ADDR_W-1:0]            dbg_addr,
    output logic [DATA_W-1:0]            dbg_data
);

    localparam int LINE_W = DATA_W * LINE_WORDS;
    localparam int CNT_W  = cnt_width(LATENCY);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(LINE_WORDS - 1);

    state_t state, next_state;

    logic [CNT_W-1:0]      cnt;
    logic [ADDR_W-1:0]     req_addr;
    logic                  req_rw;
    logic [LINE_WORDS-1:0] req_wstrb;
    logic [LINE_W-1:0]     req_wdata;

    logic                  accept;
    logic                  finish_wait;
    logic                  commit;
    logic [ADDR_W-1:0]     commit_addr;
    logic                  commit_rw;
    logic [LINE_WORDS-1:0] commit_wstrb;
    logic [LINE_W-1:0]     commit_wdata;
    logic                  array_we;
    logic [LINE_W-1:0]     line_rdata;

    assign accept      = (state == IDLE) && mem_req_valid;
    // The last WAIT cycle is the one whose decrement reaches zero.
    assign finish_wait = (state == WAIT) && (cnt <= CNT_W'(1));

    // The commit happens on the edge that enters DONE. With LATENCY=1 that is
    // the accepting edge itself, so the latches are not loaded yet and the
    // live request fields are used instead.
    always_comb begin
        commit       = finish_wait;
        commit_addr  = req_addr;
        commit_rw    = req_rw;
        commit_wstrb = req_wstrb;
        commit_wdata = req_wdata;
        if (LATENCY == 1) begin
            commit       = accept;
            commit_addr  = mem_req_addr & ALIGN_MASK;
            commit_rw    = mem_req_rw;
            commit_wstrb = mem_req_wstrb;
            commit_wdata = mem_data_write;
        end
    end

    assign array_we = commit && commit_rw;

    line_mem_array #(
        .DATA_W     (DATA_W),
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_array (
        .clk      (clk),
        .we       (array_we),
        .wstrb    (commit_wstrb),
        .addr     (commit_addr),
        .wdata    (commit_wdata),
        .rdata    (line_rdata),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; requests arriving outside IDLE are simply not looked at.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (mem_req_valid) begin
                    next_state = (LATENCY == 1) ? DONE : WAIT;
                end
            end
            WAIT: begin
                if (finish_wait) begin
                    next_state = DONE;
                end
            end
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Status outputs decoded from the registered state.
    always_comb begin
        mem_ready = 1'b0;
        mem_busy  = 1'b0;
        if (state == DONE) begin
            mem_ready = 1'b1;
        end
        if (state != IDLE) begin
            mem_busy = 1'b1;
        end
    end

    // Request latches, latency counter and the read-data register. The latches
    // freeze the request at acceptance so later input changes cannot leak in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt           <= '0;
            req_addr      <= '0;
            req_rw        <= 1'b0;
            req_wstrb     <= '0;
            req_wdata     <= '0;
            mem_data_read <= '0;
        end else begin
            if (accept) begin
                req_addr  <= mem_req_addr & ALIGN_MASK;
                req_rw    <= mem_req_rw;
                req_wstrb <= mem_req_wstrb;
                req_wdata <= mem_data_write;
                cnt       <= CNT_W'(LATENCY - 1);
            end else if ((state == WAIT) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit && !commit_rw) begin
                mem_data_read <= line_rdata;
            end
        end
    end

endmodule

// File: tb/tb_line_mem.sv
// tb_line_mem
// Scoreboard bench for line_mem: the driver pushes the expected completion
// (cycle and, for reads, the line) when it issues a request, and a monitor
// pops and compares whenever mem_ready is seen. Instance a uses the default
// parameters, instance b uses LATENCY=1 and LINE_WORDS=8.

module tb_line_mem;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    typedef struct {
        bit           is_read;
        logic [255:0] data;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic         valid_a = 1'b0, rw_a = 1'b0;
    logic [7:0]   addr_a = '0, dbg_addr_a = '0;
    logic [3:0]   wstrb_a = '0;
    logic [127:0] wdata_a = '0;
    logic [127:0] rdata_a;
    logic         ready_a, busy_a;
    logic [31:0]  dbg_a;

    logic         valid_b = 1'b0, rw_b = 1'b0;
    logic [7:0]   addr_b = '0, dbg_addr_b = '0;
    logic [7:0]   wstrb_b = '0;
    logic [255:0] wdata_b = '0;
    logic [255:0] rdata_b;
    logic         ready_b, busy_b;
    logic [31:0]  dbg_b;

    exp_t q_a[$];
    exp_t q_b[$];
    exp_t e_a, e_b;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int readys_a = 0;
    int readys_b = 0;

    localparam logic [127:0] LINE_0  = {32'h33, 32'h22, 32'h11, 32'h00};
    localparam logic [127:0] LINE_FF = {4{32'hFF}};
    localparam logic [127:0] LINE_C  = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    localparam logic [127:0] LINE_X  = {4{32'hEE}};
    localparam logic [127:0] LINE_D  = {32'hD3, 32'hD2, 32'hD1, 32'hD0};
    localparam logic [255:0] LINE_B  = {32'hA7, 32'hA6, 32'hA5, 32'hA4,
                                        32'hA3, 32'hA2, 32'hA1, 32'hA0};

    line_mem u_dut_a (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (valid_a),
        .mem_req_rw     (rw_a),
        .mem_req_addr   (addr_a),
        .mem_req_wstrb  (wstrb_a),
        .mem_data_write (wdata_a),
        .mem_data_read  (rdata_a),
        .mem_ready      (ready_a),
        .mem_busy       (busy_a),
        .dbg_addr       (dbg_addr_a),
        .dbg_data       (dbg_a)
    );

    line_mem #(
        .DATA_W     (32),
        .LINE_WORDS (8),
        .ADDR_W     (8),
        .LATENCY    (LAT_B)
    ) u_dut_b (
        .clk            (clk),
        .rst            (rst),
        .mem_req_valid  (valid_b),
        .mem_req_rw     (rw_b),
        .mem_req_addr   (addr_b),
        .mem_req_wstrb  (wstrb_b),
        .mem_data_write (wdata_b),
        .mem_data_read  (rdata_b),
        .mem_ready      (ready_b),
        .mem_busy       (busy_b),
        .dbg_addr       (dbg_addr_b),
        .dbg_data       (dbg_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every completion pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (!rst && ready_a) begin
            readys_a++;
            if (q_a.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL a_unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e_a = q_a.pop_front();
                check_output("a_ready_cycle", 256'(cyc), 256'(e_a.due));
                if (e_a.is_read) check_output("a_read_line", 256'(rdata_a), e_a.data);
            end
        end
        if (!rst && ready_b) begin
            readys_b++;
            if (q_b.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL b_unexpected_ready: got ready at cycle %0d expected none", cyc);
            end else begin
                e_b = q_b.pop_front();
                check_output("b_ready_cycle", 256'(cyc), 256'(e_b.due));
                if (e_b.is_read) check_output("b_read_line", rdata_b, e_b.data);
            end
        end
    end

    // Bounded wait for the completion pulse, sampled on negedges.
    task automatic wait_ready(input bit sel);
        for (int k = 0; k < 16; k++) begin
            if (sel ? ready_b : ready_a) break;
            @(negedge clk);
        end
        if (!(sel ? ready_b : ready_a)) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s_ready_timeout: got no ready expected ready", sel ? "b" : "a");
        end
    endtask

    // Issue one request, register its expected completion, hold it until
    // mem_ready, then drop valid so the following IDLE cycle sees no request.
    task automatic apply_stimulus(input bit sel, input bit rw, input logic [7:0] addr,
                                  input logic [7:0] wstrb, input logic [255:0] line,
                                  input logic [255:0] exp_read);
        exp_t e;
        @(negedge clk);
        e.is_read = !rw;
        e.data    = exp_read;
        if (!sel) begin
            valid_a = 1'b1; rw_a = rw; addr_a = addr; wstrb_a = wstrb[3:0]; wdata_a = line[127:0];
            e.due = cyc + LAT_A;
            q_a.push_back(e);
        end else begin
            valid_b = 1'b1; rw_b = rw; addr_b = addr; wstrb_b = wstrb; wdata_b = line;
            e.due = cyc + LAT_B;
            q_b.push_back(e);
        end
        @(negedge clk);
        check_output(sel ? "b_busy_in_flight" : "a_busy_in_flight", 256'(sel ? busy_b : busy_a), 256'(1));
        wait_ready(sel);
        if (!sel) valid_a = 1'b0;
        else      valid_b = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_dbg(input bit sel, input logic [7:0] addr, input logic [31:0] exp);
        @(negedge clk);
        if (!sel) dbg_addr_a = addr;
        else      dbg_addr_b = addr;
        #1;
        check_output($sformatf("%s_dbg_%0h", sel ? "b" : "a", addr), 256'(sel ? dbg_b : dbg_a), 256'(exp));
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        check_output("a_reset_ready", 256'(ready_a), 256'(0));
        check_output("a_reset_busy", 256'(busy_a), 256'(0));
        check_output("a_reset_rdata", 256'(rdata_a), 256'(0));
        check_output("b_reset_rdata", rdata_b, 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Full-line write, then word check through the debug port.
        apply_stimulus(0, 1, 8'h10, 8'hF, 256'(LINE_0), '0);
        check_output("a_busy_idle", 256'(busy_a), 256'(0));
        check_dbg(0, 8'h12, 32'h22);
        check_dbg(0, 8'h13, 32'h33);

        // Unaligned read address lands on the same line.
        apply_stimulus(0, 0, 8'h13, 8'h0, '0, 256'(LINE_0));

        // Partial strobe write; the read line must survive it.
        apply_stimulus(0, 1, 8'h10, 8'h5, 256'(LINE_FF), '0);
        check_output("a_rdata_held_after_write", 256'(rdata_a), 256'(LINE_0));
        check_dbg(0, 8'h10, 32'hFF);
        check_dbg(0, 8'h11, 32'h11);
        check_dbg(0, 8'h12, 32'hFF);
        check_dbg(0, 8'h13, 32'h33);

        // Zero strobe: completes, changes nothing.
        apply_stimulus(0, 1, 8'h10, 8'h0, '0, '0);
        check_dbg(0, 8'h10, 32'hFF);
        check_dbg(0, 8'h11, 32'h11);

        // In-flight request is frozen at acceptance; valid in DONE is ignored.
        @(negedge clk);
        valid_a = 1'b1; rw_a = 1'b1; addr_a = 8'h30; wstrb_a = 4'hF; wdata_a = LINE_C;
        e_a.is_read = 1'b0; e_a.data = '0; e_a.due = cyc + LAT_A;
        q_a.push_back(e_a);
        @(negedge clk);
        valid_a = 1'b0; rw_a = 1'b0; addr_a = 8'h40; wstrb_a = 4'h0; wdata_a = LINE_X;
        wait_ready(0);
        valid_a = 1'b1;
        @(negedge clk);
        valid_a = 1'b0;
        repeat (4) @(negedge clk);
        check_dbg(0, 8'h30, 32'hC0);
        check_dbg(0, 8'h33, 32'hC3);
        check_dbg(0, 8'h40, 32'h0);
        check_output("a_rdata_held_after_frozen_write", 256'(rdata_a), 256'(LINE_0));

        apply_stimulus(0, 0, 8'h31, 8'h0, '0, 256'(LINE_C));

        // Reset one cycle after accepting a write aborts it.
        @(negedge clk);
        valid_a = 1'b1; rw_a = 1'b1; addr_a = 8'h20; wstrb_a = 4'hF; wdata_a = LINE_D;
        @(negedge clk);
        check_output("a_busy_before_abort", 256'(busy_a), 256'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        valid_a = 1'b0;
        #1;
        check_output("a_abort_ready", 256'(ready_a), 256'(0));
        check_output("a_abort_busy", 256'(busy_a), 256'(0));
        check_output("a_abort_rdata", 256'(rdata_a), 256'(0));
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check_dbg(0, 8'h20, 32'h0);
        check_dbg(0, 8'h10, 32'hFF);

        // LATENCY=1, 8-word lines, top line of the address space.
        apply_stimulus(1, 1, 8'hF8, 8'hFF, LINE_B, '0);
        apply_stimulus(1, 0, 8'hFA, 8'h0, '0, LINE_B);
        check_dbg(1, 8'hFF, 32'hA7);
        check_dbg(1, 8'hF8, 32'hA0);
        check_dbg(1, 8'h00, 32'h0);

        repeat (3) @(negedge clk);
        check_output("a_ready_count", 256'(readys_a), 256'(6));
        check_output("b_ready_count", 256'(readys_b), 256'(2));
        check_output("a_queue_drained", 256'(q_a.size()), 256'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/line_mem.md
LINE_MEM -- requirements
Module: line_mem

Interface
REQ-001 SHALL have parameter DATA_W, default 32, word width in bits.
REQ-002 SHALL have parameter LINE_WORDS, default 4, words per line; power of two, at least 1.
REQ-003 SHALL have parameter ADDR_W, default 8, word-address width; depth = 2^ADDR_W words, at least LINE_WORDS.
REQ-004 SHALL have parameter LATENCY, default 3, cycles from acceptance to mem_ready; at least 1.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port mem_req_valid, input, 1, request present.
REQ-008 SHALL have port mem_req_rw, input, 1, 1 = write, 0 = read.
REQ-009 SHALL have port mem_req_addr, input, ADDR_W, word address; low log2(LINE_WORDS) bits ignored (line-aligned).
REQ-010 SHALL have port mem_req_wstrb, input, LINE_WORDS, per-word write enable; bit i covers word i.
REQ-011 SHALL have port mem_data_write, input, DATA_W*LINE_WORDS, write line; word i at bits [DATA_W*(i+1)-1 : DATA_W*i].
REQ-012 SHALL have port mem_data_read, output, DATA_W*LINE_WORDS, registered read line, same packing.
REQ-013 SHALL have port mem_ready, output, 1, one-cycle completion pulse.
REQ-014 SHALL have port mem_busy, output, 1, high whenever state is not IDLE.
REQ-015 SHALL have port dbg_addr, input, ADDR_W, debug word address.
REQ-016 SHALL have port dbg_data, output, DATA_W, combinational word at dbg_addr.

Function
REQ-017 SHALL implement FSM IDLE -> WAIT -> DONE -> IDLE.
REQ-018 In IDLE, mem_req_valid=1 SHALL accept: latch aligned address, rw, wstrb and write data; load counter with LATENCY-1; go to WAIT, or to DONE directly when LATENCY=1.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at count 0 go to DONE.
REQ-020 On the edge entering DONE, a write SHALL commit only the strobed words, and a read SHALL load mem_data_read from the latched line.
REQ-021 mem_ready SHALL be high exactly during DONE: an acceptance at edge T gives mem_ready high in cycle T+LATENCY, for one cycle.
REQ-022 mem_req_valid SHALL be ignored in WAIT and DONE.
  - The requester holds valid and all request fields until mem_ready is seen.
  - The requester deasserts valid in the cycle after mem_ready; the earliest re-acceptance is the IDLE cycle following DONE.
REQ-023 Input changes after acceptance SHALL NOT affect the in-flight operation.
REQ-024 mem_data_read SHALL hold its value until the next read completes; writes SHALL NOT change it.
REQ-025 A write with mem_req_wstrb=0 SHALL complete with mem_ready and leave memory unchanged.
REQ-026 Line words SHALL occupy aligned_addr+0 .. aligned_addr+LINE_WORDS-1, with no address wrap; the top line is fully in range.
REQ-027 dbg_data SHALL show a committed write from the edge it commits.

Reset
REQ-028 rst=1 SHALL immediately force:
  - state IDLE, counter 0;
  - mem_ready 0, mem_busy 0;
  - mem_data_read all zeros.
REQ-029 Reset during WAIT SHALL abort the operation: no write commit, no mem_ready.
REQ-030 Reset SHALL NOT clear the memory array; the array SHALL be zero-initialised at time zero only.

Structure
REQ-031 Shared package line_mem_pkg SHALL hold the state typedef (IDLE, WAIT, DONE) and the default parameter constants.
REQ-032 Storage SHALL be one sub-module, line_mem_array: word-strobed line write, combinational line read, combinational debug read.
REQ-033 The FSM, latency counter and request latches SHALL live in line_mem.

Verification
REQ-034 Defaults: write addr 0x10, wstrb 4'b1111, data {D3,D2,D1,D0}={0x33,0x22,0x11,0x00}, accepted at edge T -> mem_ready only in cycle T+3; dbg_addr 0x12 reads 0x22.
REQ-035 Read addr 0x13 after REQ-034 -> address aligns to 0x10; mem_data_read = {0x33,0x22,0x11,0x00} in the ready cycle and held through a later write.
REQ-036 Write addr 0x10, wstrb 4'b0101, data all 0xFF -> words 0x10 and 0x12 read 0xFF; words 0x11 and 0x13 keep 0x11 and 0x33.
REQ-037 Change addr and data during WAIT, and pulse valid in DONE -> the original operation completes and only one mem_ready is seen.
REQ-038 Assert rst one cycle after accepting a write to 0x20 -> no mem_ready; word 0x20 stays 0; outputs are at reset values immediately.
REQ-039 LATENCY=1, LINE_WORDS=8: write then read the top line 0xF8 -> each operation has mem_ready at T+1; the read returns the written data with no wrap into 0x00.
